// File: rtl/bus_arbiter_if.sv
// ============================================================================
// Module      : bus_arbiter_if
// Description : Request/grant bundle between the bus arbiter and its eight
//               requesters (register file ports, ALU, memory interface, ...).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_arbiter_if;
    logic [7:0] req;
    logic [7:0] done;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       bus_busy;
    logic       timeout;

    // master = arbiter side, slave = requester/bus-mux side
    modport master (
        input  req, done,
        output grant, sel, bus_busy, timeout
    );

    modport slave (
        output req, done,
        input  grant, sel, bus_busy, timeout
    );
endinterface

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module      : bus_arbiter
// Description : Round-robin owner arbiter for the 8-bit internal bus with hold
//               limit and a one-cycle dead turnaround between owners.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  wire logic     clk,
    input  wire logic     reset,
    bus_arbiter_if.master bus
);

    localparam int c_CNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t             r_state;
    logic [2:0]         r_ptr;
    logic [c_CNT_W-1:0] r_cnt;
    logic [7:0]         r_grant;
    logic [2:0]         r_sel;
    logic               r_busy;
    logic               r_timeout;

    logic       w_any_req;
    logic [2:0] w_win;
    logic [2:0] w_idx;
    logic       w_own_req;
    logic       w_own_done;
    logic       w_hold_max;

    assign w_any_req  = |bus.req;
    assign w_own_req  = bus.req[r_sel];
    assign w_own_done = bus.done[r_sel];
    assign w_hold_max = (r_cnt == c_CNT_W'(MAX_HOLD));

    // Scan from farthest to nearest so the first requester after r_ptr wins.
    always_comb begin
        w_win = r_ptr;
        w_idx = r_ptr;
        for (int k = 7; k >= 0; k--) begin
            w_idx = r_ptr + 3'(k);
            if (bus.req[w_idx]) begin
                w_win = w_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= 3'd0;
            r_cnt     <= '0;
            r_grant   <= 8'd0;
            r_sel     <= 3'd0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE, S_RELEASE: begin
                    if (w_any_req) begin
                        r_state <= S_GRANT;
                        r_grant <= 8'd1 << w_win;
                        r_sel   <= w_win;
                        r_busy  <= 1'b1;
                        r_ptr   <= w_win + 3'd1;
                        r_cnt   <= c_CNT_W'(1);
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_GRANT: begin
                    if (w_own_done || !w_own_req || w_hold_max) begin
                        r_state   <= S_RELEASE;
                        r_grant   <= 8'd0;
                        r_busy    <= 1'b0;
                        // Only a pure hold-limit release counts as a timeout.
                        r_timeout <= w_hold_max && !w_own_done && w_own_req;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= 8'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant    = r_grant;
    assign bus.sel      = r_sel;
    assign bus.bus_busy = r_busy;
    assign bus.timeout  = r_timeout;

endmodule

`default_nettype wire
